// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - datapath, external memory and device I/O signals of mem_ctrl
interface mem_ctrl_if;
    logic        MIO_EN;
    logic        R_W;
    logic        LD_MAR;
    logic        LD_MDR;
    logic [15:0] BUS;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        R;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        INT;
    logic        KB_VALID;
    logic [7:0]  KB_DATA;
    logic        DISP_READY;
    logic        DISP_VALID;
    logic [7:0]  DISP_DATA;

    modport slave (
        input  MIO_EN, R_W, LD_MAR, LD_MDR, BUS, mem_rdata, KB_VALID, KB_DATA, DISP_READY,
        output MAR, MDR, R, mem_addr, mem_wdata, mem_we, mem_re, INT, DISP_VALID, DISP_DATA
    );

    modport master (
        output MIO_EN, R_W, LD_MAR, LD_MDR, BUS, mem_rdata, KB_VALID, KB_DATA, DISP_READY,
        input  MAR, MDR, R, mem_addr, mem_wdata, mem_we, mem_re, INT, DISP_VALID, DISP_DATA
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - LC-3 style MAR/MDR memory controller with wait states
// Optional memory-mapped keyboard/display registers when LC3_MMIO_EN is defined.
module mem_ctrl #(
    parameter int WAIT_STATES = 4
) (
    input logic       CLK,
    input logic       RESET,
    mem_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        rw_q;
    logic [15:0] mar_q, mdr_q;
    logic        r_q;
    logic        mmio_hit;
    logic        mmio_go;
    logic        mmio_rd;
    logic [15:0] mmio_rdata;
    logic        mem_load;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (io.MIO_EN) begin
                    if (mmio_hit) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ACCESS;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ACCESS: begin
                if (!io.MIO_EN) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_load = (state == ACCESS) && (state_nxt == DONE) && !rw_q;
    assign mmio_go  = (state == IDLE) && (state_nxt == DONE);
    assign mmio_rd  = mmio_go && !io.R_W;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rw_q  <= 1'b0;
            mar_q <= 16'd0;
            mdr_q <= 16'd0;
            r_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            r_q   <= (state_nxt == DONE);
            if (state == IDLE && io.MIO_EN)
                rw_q <= io.R_W;
            if (state == IDLE && io.LD_MAR)
                mar_q <= io.BUS;
            // A pending memory read owns MDR; bus loads only when no read is requested.
            if (mem_load)
                mdr_q <= io.mem_rdata;
            else if (mmio_rd)
                mdr_q <= mmio_rdata;
            else if (io.LD_MDR && !(io.MIO_EN && !io.R_W))
                mdr_q <= io.BUS;
        end
    end

    assign io.MAR       = mar_q;
    assign io.MDR       = mdr_q;
    assign io.R         = r_q;
    assign io.mem_addr  = mar_q;
    assign io.mem_wdata = mdr_q;
    assign io.mem_re    = (state == ACCESS) && !rw_q;
    assign io.mem_we    = (state == ACCESS) && rw_q;

`ifdef LC3_MMIO_EN
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    logic       kb_rdy, kb_ie;
    logic [7:0] kbdr;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       int_q;

    assign mmio_hit = (mar_q == ADDR_KBSR) || (mar_q == ADDR_KBDR) ||
                      (mar_q == ADDR_DSR)  || (mar_q == ADDR_DDR);

    always_comb begin
        mmio_rdata = 16'd0;
        case (mar_q)
            ADDR_KBSR: mmio_rdata = {kb_rdy, kb_ie, 14'd0};
            ADDR_KBDR: mmio_rdata = {8'd0, kbdr};
            ADDR_DSR:  mmio_rdata = {io.DISP_READY, 15'd0};
            default:   mmio_rdata = 16'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            kb_rdy     <= 1'b0;
            kb_ie      <= 1'b0;
            kbdr       <= 8'd0;
            disp_valid <= 1'b0;
            disp_data  <= 8'd0;
            int_q      <= 1'b0;
        end else begin
            disp_valid <= mmio_go && io.R_W && (mar_q == ADDR_DDR);
            if (mmio_go && io.R_W && (mar_q == ADDR_DDR))
                disp_data <= mdr_q[7:0];
            // New keystroke beats a simultaneous KBDR read clearing the ready flag.
            if (io.KB_VALID) begin
                kb_rdy <= 1'b1;
                kbdr   <= io.KB_DATA;
            end else if (mmio_rd && (mar_q == ADDR_KBDR)) begin
                kb_rdy <= 1'b0;
            end
            if (mmio_go && io.R_W && (mar_q == ADDR_KBSR))
                kb_ie <= mdr_q[14];
            int_q <= kb_rdy & kb_ie;
        end
    end

    assign io.INT        = int_q;
    assign io.DISP_VALID = disp_valid;
    assign io.DISP_DATA  = disp_data;
`else
    logic unused_dev;

    assign mmio_hit      = 1'b0;
    assign mmio_rdata    = 16'd0;
    assign unused_dev    = ^{io.KB_VALID, io.KB_DATA, io.DISP_READY};
    assign io.INT        = 1'b0;
    assign io.DISP_VALID = 1'b0;
    assign io.DISP_DATA  = 8'd0;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard testbench for mem_ctrl
module tb_mem_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if io();

    mem_ctrl #(.WAIT_STATES(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .io    (io.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] mdr;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] v);
        io.BUS    = v;
        io.LD_MAR = 1'b1;
        tick();
        io.LD_MAR = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        io.BUS    = v;
        io.LD_MDR = 1'b1;
        tick();
        io.LD_MDR = 1'b0;
    endtask

    task automatic access(input string tag, input logic [15:0] addr, input logic rw,
                          input logic [15:0] rdata, input logic [15:0] exp_mdr,
                          input int exp_lat, input int exp_strobes, input int exp_dv,
                          input bit disturb);
        int   n, strobes, wrong, bad, dv;
        bit   seen;
        exp_t e;
        n = 0; strobes = 0; wrong = 0; bad = 0; dv = 0; seen = 1'b0;
        load_mar(addr);
        io.mem_rdata = rdata;
        io.R_W       = rw;
        io.MIO_EN    = 1'b1;
        sb.push_back('{mdr: exp_mdr, lat: exp_lat});
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            n = i;
            if (disturb && i == 1) begin
                io.LD_MAR = 1'b1;
                io.LD_MDR = 1'b1;
                io.BUS    = 16'hDEAD;
            end
            if (disturb && i == 2) begin
                io.LD_MAR = 1'b0;
                io.LD_MDR = 1'b0;
                io.R_W    = ~rw;
            end
            if (disturb && i == 3)
                io.R_W = rw;
            if (io.mem_we || io.mem_re) begin
                if ((io.mem_we && !rw) || (io.mem_re && rw))
                    wrong++;
                else
                    strobes++;
                if (io.mem_addr !== addr)
                    bad++;
                if (rw && io.mem_wdata !== exp_mdr)
                    bad++;
            end
            dv += int'(io.DISP_VALID);
            if (io.R)
                seen = 1'b1;
        end
        io.MIO_EN = 1'b0;
        check({tag, " r_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        check({tag, " latency"}, 32'(n), 32'(e.lat));
        check({tag, " mdr"}, 32'(io.MDR), 32'(e.mdr));
        check({tag, " strobes"}, 32'(strobes), 32'(exp_strobes));
        check({tag, " wrong_dir"}, 32'(wrong), 32'd0);
        check({tag, " addr_data"}, 32'(bad), 32'd0);
        tick();
        dv += int'(io.DISP_VALID);
        check({tag, " r_one_cycle"}, 32'(io.R), 32'd0);
        check({tag, " disp_valid"}, 32'(dv), 32'(exp_dv));
    endtask

    initial begin
        int rcnt, gap;
        bit seen;
        io.MIO_EN = 0; io.R_W = 0; io.LD_MAR = 0; io.LD_MDR = 0; io.BUS = 0;
        io.mem_rdata = 0; io.KB_VALID = 0; io.KB_DATA = 0; io.DISP_READY = 0;

        rst = 1'b1;
        tick(); tick();
        check("rst mar", 32'(io.MAR), 32'd0);
        check("rst mdr", 32'(io.MDR), 32'd0);
        check("rst r", 32'(io.R), 32'd0);
        check("rst we_re", 32'({io.mem_we, io.mem_re}), 32'd0);
        check("rst int_dv", 32'({io.INT, io.DISP_VALID}), 32'd0);
        rst = 1'b0;
        tick();

        access("read", 16'h3000, 1'b0, 16'h1234, 16'h1234, W + 1, W, 0, 1'b0);
        load_mdr(16'hBEEF);
        access("write", 16'h4000, 1'b1, 16'h0000, 16'hBEEF, W + 1, W, 0, 1'b0);
        access("read_dist", 16'h3000, 1'b0, 16'h5A5A, 16'h5A5A, W + 1, W, 0, 1'b1);

        // abort after two ACCESS cycles
        load_mar(16'h3000);
        io.mem_rdata = 16'h5555;
        io.R_W       = 1'b0;
        io.MIO_EN    = 1'b1;
        tick(); tick();
        io.MIO_EN = 1'b0;
        rcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            rcnt += int'(io.R);
        end
        check("abort r", 32'(rcnt), 32'd0);
        check("abort mdr", 32'(io.MDR), 32'h5A5A);
        check("abort re", 32'(io.mem_re), 32'd0);

        // held request restarts after DONE
        io.mem_rdata = 16'h0A0A;
        io.R_W       = 1'b0;
        io.MIO_EN    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (io.R) seen = 1'b1;
        end
        check("b2b first", 32'(seen), 32'd1);
        gap = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            gap = i;
            if (io.R) seen = 1'b1;
        end
        io.MIO_EN = 1'b0;
        check("b2b gap", 32'(gap), 32'(W + 2));
        check("b2b mdr", 32'(io.MDR), 32'h0A0A);
        tick(); tick();

        // reset in the middle of a write
        load_mdr(16'hBEEF);
        load_mar(16'h4000);
        io.R_W    = 1'b1;
        io.MIO_EN = 1'b1;
        tick(); tick();
        check("midrst pre_we", 32'(io.mem_we), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst we", 32'(io.mem_we), 32'd0);
        check("midrst r", 32'(io.R), 32'd0);
        check("midrst mar", 32'(io.MAR), 32'd0);
        check("midrst mdr", 32'(io.MDR), 32'd0);
        rst = 1'b0;
        io.MIO_EN = 1'b0;
        tick();

`ifdef LC3_MMIO_EN
        io.KB_DATA  = 8'h41;
        io.KB_VALID = 1'b1;
        tick();
        io.KB_VALID = 1'b0;
        load_mdr(16'h4000);
        access("kbsr_wr", 16'hFE00, 1'b1, 16'h0000, 16'h4000, 1, 0, 0, 1'b0);
        check("int set", 32'(io.INT), 32'd1);
        access("kbdr_rd", 16'hFE02, 1'b0, 16'hFFFF, 16'h0041, 1, 0, 0, 1'b0);
        check("int clr", 32'(io.INT), 32'd0);
        access("kbsr_rd", 16'hFE00, 1'b0, 16'hFFFF, 16'h4000, 1, 0, 0, 1'b0);
        load_mdr(16'h0058);
        access("ddr_wr", 16'hFE06, 1'b1, 16'h0000, 16'h0058, 1, 0, 1, 1'b0);
        check("disp data", 32'(io.DISP_DATA), 32'h58);
`else
        io.KB_DATA    = 8'h41;
        io.KB_VALID   = 1'b1;
        io.DISP_READY = 1'b1;
        tick();
        io.KB_VALID = 1'b0;
        check("nommio int", 32'(io.INT), 32'd0);
        check("nommio dv", 32'(io.DISP_VALID), 32'd0);
        check("nommio dd", 32'(io.DISP_DATA), 32'd0);
        access("ext_fe02", 16'hFE02, 1'b0, 16'h7777, 16'h7777, W + 1, W, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 4, number of ACCESS cycles per memory transfer (legal 1..15).
REQ-002 SHALL have port CLK  in  1  rising-edge clock.
REQ-003 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have port MIO_EN  in  1  memory operation request, held by current microstate.
REQ-005 SHALL have port R_W  in  1  1 = write, 0 = read; sampled with MIO_EN.
REQ-006 SHALL have ports LD_MAR and LD_MDR  in  1 each  register load strobes from the bus.
REQ-007 SHALL have port BUS  in  16  datapath bus.
REQ-008 SHALL have ports MAR and MDR  out  16 each  address and data registers.
REQ-009 SHALL have port R  out  1  memory-ready to microsequencer, registered.
REQ-010 SHALL have ports mem_addr  out  16, mem_wdata  out  16, mem_we  out  1, mem_re  out  1, mem_rdata  in  16  external memory.
REQ-011 SHALL have ports INT  out  1, KB_VALID  in  1, KB_DATA  in  8, DISP_READY  in  1, DISP_VALID  out  1, DISP_DATA  out  8  device I/O.

Function
REQ-012 SHALL implement FSM IDLE, ACCESS, DONE; wait counter 4 bits.
REQ-013 IDLE: MIO_EN=1 -> ACCESS with counter=WAIT_STATES-1; else stay.
REQ-014 ACCESS: counter decrements each cycle; counter=0 -> DONE.
REQ-015 DONE: R=1 for exactly that one cycle; next state IDLE unconditionally.
REQ-016 R SHALL be 0 in IDLE and ACCESS; first R=1 occurs WAIT_STATES+1 cycles after the cycle MIO_EN is sampled in IDLE.
REQ-017 mem_addr SHALL equal MAR at all times; mem_wdata SHALL equal MDR.
REQ-018 mem_re=1 and mem_we=0 throughout ACCESS when R_W=0; mem_we=1 and mem_re=0 throughout ACCESS when R_W=1; both 0 in IDLE and DONE.
REQ-019 Read: MDR SHALL load mem_rdata on the ACCESS->DONE edge.
REQ-020 MIO_EN=0 during ACCESS SHALL abort to IDLE next cycle, no MDR update, R stays 0.
REQ-021 LD_MAR SHALL load MAR from BUS only in IDLE; ignored otherwise.
REQ-022 LD_MDR with MIO_EN=0 SHALL load MDR from BUS; LD_MDR with MIO_EN=1, R_W=0 SHALL be a no-op (memory load per REQ-019 governs).
REQ-023 MIO_EN still 1 in IDLE after DONE SHALL start a new access (re-request is the requester's responsibility).
REQ-024 R_W SHALL be latched on IDLE->ACCESS; changes during ACCESS ignored.

Reset
REQ-025 RESET SHALL force state IDLE, counter 0, MAR=0, MDR=0, R=0, mem_we=0, mem_re=0, DISP_VALID=0, KBSR=0, KBDR=0, INT=0, overriding all other inputs, including mid-ACCESS.

Configuration
REQ-026 Macro LC3_MMIO_EN defined: addresses xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR SHALL be decoded internally; accesses to them go IDLE->DONE directly (R one cycle after request), mem_re/mem_we stay 0.
REQ-027 With LC3_MMIO_EN: KB_VALID=1 sets KBSR[15] and loads KBDR[7:0]=KB_DATA; a KBDR read clears KBSR[15] (KB_VALID in the same cycle wins); KBSR[14] writable; DSR[15]=DISP_READY; a DDR write pulses DISP_VALID one cycle with DISP_DATA=MDR[7:0]; INT=KBSR[15]&KBSR[14], registered.
REQ-028 Without LC3_MMIO_EN: all addresses go to external memory, INT=0, DISP_VALID=0, DISP_DATA=0, KB_VALID/KB_DATA/DISP_READY ignored; ports remain.

Verification
REQ-029 Reset, BUS=x3000 LD_MAR, MIO_EN=1 R_W=0, mem_rdata=x1234 -> R=1 exactly 5 cycles later for one cycle, MDR=x1234.
REQ-030 MAR=x4000, LD_MDR with BUS=xBEEF, MIO_EN=1 R_W=1 -> mem_we=1 for 4 cycles with mem_addr=x4000, mem_wdata=xBEEF, then R=1.
REQ-031 Read started, MIO_EN dropped after 2 ACCESS cycles -> IDLE, R never 1, MDR unchanged.
REQ-032 RESET asserted mid-ACCESS write -> next cycle mem_we=0, R=0, MAR=MDR=0.
REQ-033 LC3_MMIO_EN: KB_VALID with KB_DATA=x41, write KBSR=x4000 -> INT=1; read xFE02 -> R one cycle after request, MDR=x0041, KBSR[15]=0, INT=0.
REQ-034 LC3_MMIO_EN: write xFE06 with MDR=x0058 -> DISP_VALID=1 one cycle, DISP_DATA=x58, mem_we stays 0.
